// File: rtl/conv27_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : conv27_mac_sequencer
// Purpose  : Drives the 27-lane multiplier array one group per pass and
//            accumulates the reduced lane products with signed saturation.
// Revision : 1.0  initial release
// ============================================================================
module conv27_mac_sequencer #(
  parameter int BITSIZE   = 14,
  parameter int FRAC_BITS = 7,
  parameter int LANES     = 27,
  parameter int GRP_W     = 8,
  parameter int ADDR_W    = 10,
  parameter int ACC_W     = 32,
  parameter int WAIT_MAX  = 16,
  localparam int PW       = 2*BITSIZE - FRAC_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [GRP_W-1:0]    cmd_groups,
  input  logic [ADDR_W-1:0]   cmd_base,
  output logic                buf_rd_en,
  output logic [ADDR_W-1:0]   buf_rd_addr,
  output logic                mul_start,
  input  logic                mul_valid,
  input  logic [PW*LANES-1:0] mul_result,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_W-1:0]    out_data,
  output logic                out_err
);

  localparam int SUM_W = PW + $clog2(LANES);
  localparam int TMR_W = $clog2(WAIT_MAX);
  localparam logic [TMR_W-1:0] WAIT_LAST = TMR_W'(WAIT_MAX - 1);
  localparam logic [ACC_W-1:0] ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_LOAD = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [GRP_W-1:0]  groups_q, groups_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [GRP_W-1:0]  idx_q, idx_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              err_q, err_d;
  logic              mul_valid_q, mul_valid_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              buf_rd_en_q, buf_rd_en_d;
  logic [ADDR_W-1:0] buf_rd_addr_q, buf_rd_addr_d;
  logic              mul_start_q, mul_start_d;
  logic              out_valid_q, out_valid_d;
  logic [ACC_W-1:0]  out_data_q, out_data_d;
  logic              out_err_q, out_err_d;

  logic [SUM_W-1:0]  w_lane_ext [LANES];
  logic [SUM_W-1:0]  w_lane_sum;
  logic [ACC_W:0]    w_acc_sum;
  logic [ACC_W-1:0]  w_acc_sat;
  logic              w_new_result;
  logic              w_last;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign w_lane_ext[i] = {{(SUM_W-PW){mul_result[i*PW+PW-1]}}, mul_result[i*PW +: PW]};
  end

  // Lane reduction is exact in SUM_W bits, so only the accumulate can overflow.
  always_comb begin
    w_lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      w_lane_sum = w_lane_sum + w_lane_ext[i];
    end
  end

  assign w_acc_sum = {acc_q[ACC_W-1], acc_q}
                   + {{(ACC_W+1-SUM_W){w_lane_sum[SUM_W-1]}}, w_lane_sum};
  assign w_acc_sat = (w_acc_sum[ACC_W] != w_acc_sum[ACC_W-1])
                   ? (w_acc_sum[ACC_W] ? ACC_MIN : ACC_MAX)
                   : w_acc_sum[ACC_W-1:0];

  // Only a rising mul_valid counts, so a level left high from earlier is not a result.
  assign w_new_result = mul_valid & ~mul_valid_q;
  assign w_last       = (idx_q == groups_q - GRP_W'(1));

  always_comb begin
    state_d     = state_q;
    groups_d    = groups_q;
    base_d      = base_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    timer_d     = timer_q;
    err_d       = err_q;
    mul_valid_d = mul_valid;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          groups_d = cmd_groups;
          base_d   = cmd_base;
          acc_d    = '0;
          idx_d    = '0;
          err_d    = 1'b0;
          state_d  = (cmd_groups == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: state_d = S_LOAD;
      S_LOAD: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (w_new_result) begin
          acc_d = w_acc_sat;
          if (w_last) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + GRP_W'(1);
            state_d = S_READ;
          end
        end else if (timer_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they align with it.
    cmd_ready_d   = (state_d == S_IDLE);
    buf_rd_en_d   = (state_d == S_READ);
    buf_rd_addr_d = (state_d == S_READ) ? base_d + ADDR_W'(idx_d) : '0;
    mul_start_d   = (state_d == S_LOAD);
    out_valid_d   = (state_d == S_DONE);
    out_data_d    = (state_d == S_DONE) ? acc_d : '0;
    out_err_d     = (state_d == S_DONE) ? err_d : 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      groups_q      <= '0;
      base_q        <= '0;
      idx_q         <= '0;
      acc_q         <= '0;
      timer_q       <= '0;
      err_q         <= 1'b0;
      mul_valid_q   <= 1'b0;
      cmd_ready_q   <= 1'b1;
      buf_rd_en_q   <= 1'b0;
      buf_rd_addr_q <= '0;
      mul_start_q   <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      groups_q      <= groups_d;
      base_q        <= base_d;
      idx_q         <= idx_d;
      acc_q         <= acc_d;
      timer_q       <= timer_d;
      err_q         <= err_d;
      mul_valid_q   <= mul_valid_d;
      cmd_ready_q   <= cmd_ready_d;
      buf_rd_en_q   <= buf_rd_en_d;
      buf_rd_addr_q <= buf_rd_addr_d;
      mul_start_q   <= mul_start_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_err_q     <= out_err_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign buf_rd_en   = buf_rd_en_q;
  assign buf_rd_addr = buf_rd_addr_q;
  assign mul_start   = mul_start_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_err     = out_err_q;

endmodule
`default_nettype wire

// File: tb/tb_conv27_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv27_mac_sequencer
// Purpose  : Self-checking bench: directed table, reset corner, random runs.
// Revision : 1.0  initial release
// ============================================================================
module tb_conv27_mac_sequencer;

  localparam int PW    = 21;
  localparam int LANES = 27;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                cmd_valid = 1'b0;
  logic [7:0]          cmd_groups = '0;
  logic [9:0]          cmd_base = '0;
  logic                mul_valid = 1'b0;
  logic [PW*LANES-1:0] mul_result = '0;
  logic                out_ready = 1'b0;

  logic                cmd_ready, buf_rd_en, mul_start, out_valid, out_err;
  logic [9:0]          buf_rd_addr;
  logic [31:0]         out_data;
  logic                cmd_ready26, buf_rd_en26, mul_start26, out_valid26, out_err26;
  logic [9:0]          buf_rd_addr26;
  logic [25:0]         out_data26;

  always #5 clk = ~clk;

  conv27_mac_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_groups(cmd_groups), .cmd_base(cmd_base), .buf_rd_en(buf_rd_en),
    .buf_rd_addr(buf_rd_addr), .mul_start(mul_start), .mul_valid(mul_valid),
    .mul_result(mul_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err)
  );

  conv27_mac_sequencer #(.ACC_W(26)) dut26 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready26),
    .cmd_groups(cmd_groups), .cmd_base(cmd_base), .buf_rd_en(buf_rd_en26),
    .buf_rd_addr(buf_rd_addr26), .mul_start(mul_start26), .mul_valid(mul_valid),
    .mul_result(mul_result), .out_valid(out_valid26), .out_ready(out_ready),
    .out_data(out_data26), .out_err(out_err26)
  );

  typedef struct {
    int     groups;
    int     base;
    int     lat;     // array latency: mul_valid this many cycles after mul_start
    int     mmode;   // 0 normal, 1 valid held high, 2 valid never, 3 manual
    int     vmode;   // 0 all lanes = val, 1 alternate +val/-val, 2 random
    int     val;
    int     hold;    // cycles out_ready stays low in DONE
    longint e32;
    longint e26;
    int     eerr;
    int     elat;
    int     ereads;
  } vec_t;

  int     total = 0;
  int     bad = 0;
  int     mmode = 0, vmode = 0, val = 0, lat = 1, cnt = 0, nstart = 0;
  longint m32 = 0, m26 = 0;
  int     addrq[$];
  bit     lockstep_bad = 1'b0;

  task automatic chk(input string name, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  function automatic longint sat(input longint v, input int w);
    longint mx, mn;
    mx = (longint'(1) <<< (w-1)) - 1;
    mn = -(longint'(1) <<< (w-1));
    return (v > mx) ? mx : ((v < mn) ? mn : v);
  endfunction

  // Array model: produce one group's lane products and fold them into the reference sums.
  task automatic fire();
    longint s = 0;
    int lv;
    logic [31:0] r;
    for (int i = 0; i < LANES; i++) begin
      r = $urandom;
      case (vmode)
        0:       lv = val;
        1:       lv = (i % 2 == 0) ? val : -val;
        default: lv = $signed(r[20:0]);
      endcase
      mul_result[i*PW +: PW] = lv[20:0];
      s += lv;
    end
    mul_valid = 1'b1;
    m32 = sat(m32 + s, 32);
    m26 = sat(m26 + s, 26);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (mmode == 0) begin
      mul_valid = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) fire();
      end
    end else if (mmode == 1) begin
      mul_valid = 1'b1;
    end else if (mmode == 2) begin
      mul_valid = 1'b0;
    end
    if (buf_rd_en) addrq.push_back(int'(buf_rd_addr));
    if (mul_start) begin
      nstart++;
      if (mmode == 0) cnt = lat;
    end
    if ({cmd_ready26, buf_rd_en26, buf_rd_addr26, mul_start26, out_valid26}
        != {cmd_ready, buf_rd_en, buf_rd_addr, mul_start, out_valid})
      lockstep_bad = 1'b1;
  endtask

  task automatic run_cmd(input vec_t v, input bit use_model);
    longint e32, e26;
    int cyc;
    bit busy_ready;
    mmode = v.mmode; vmode = v.vmode; val = v.val; lat = v.lat;
    cnt = 0; m32 = 0; m26 = 0; nstart = 0; addrq.delete();
    mul_valid = (v.mmode == 1);
    for (int k = 0; k < 50 && !cmd_ready; k++) step();
    chk("cmd_ready_idle", longint'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_groups = 8'(v.groups); cmd_base = 10'(v.base);
    step();
    cmd_valid = 1'b0; cmd_groups = 8'($urandom); cmd_base = 10'($urandom);
    cyc = 1; busy_ready = 1'b0;
    while (!out_valid && cyc < 2000) begin
      if (cmd_ready) busy_ready = 1'b1;
      step();
      cyc++;
    end
    chk("done_reached", longint'(out_valid), 1);
    chk("cmd_ready_busy", longint'(busy_ready), 0);
    chk("latency", cyc, v.elat);
    e32 = use_model ? m32 : v.e32;
    e26 = use_model ? m26 : v.e26;
    for (int h = 0; h <= v.hold; h++) begin
      chk("out_valid_hold", longint'(out_valid), 1);
      chk("out_data32", longint'($signed(out_data)), e32);
      chk("out_data26", longint'($signed(out_data26)), e26);
      chk("out_err", longint'(out_err), v.eerr);
      chk("out_err26", longint'(out_err26), v.eerr);
      chk("cmd_ready_done", longint'(cmd_ready), 0);
      if (h < v.hold) step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("out_valid_after", longint'(out_valid), 0);
    chk("cmd_ready_after", longint'(cmd_ready), 1);
    chk("n_reads", addrq.size(), v.ereads);
    chk("n_starts", nstart, v.ereads);
    for (int i = 0; i < addrq.size(); i++)
      chk("rd_addr", addrq[i], (v.base + i) % 1024);
    chk("lockstep", longint'(lockstep_bad), 0);
  endtask

  vec_t tbl[11];
  vec_t rv;

  initial begin
    //         grp  base  lat mm vm  val       hold e32        e26        err lat rd
    tbl[0]  = '{2,   5,    2, 0, 0, 128,      0, 6912,      6912,      0,  9, 2};
    tbl[1]  = '{1,   0,    1, 0, 1, 300,      1, 300,       300,       0,  4, 1};
    tbl[2]  = '{1,   3,    3, 0, 0, -1,       0, -27,       -27,       0,  6, 1};
    tbl[3]  = '{2,   100,  1, 0, 0, 1048575,  0, 56623050,  33554431,  0,  7, 2};
    tbl[4]  = '{2,   200,  2, 0, 0, -1048576, 0, -56623104, -33554432, 0,  9, 2};
    tbl[5]  = '{1,   7,    1, 1, 0, 5,        0, 0,         0,         1, 19, 1};
    tbl[6]  = '{1,   8,    1, 2, 0, 5,        0, 0,         0,         1, 19, 1};
    tbl[7]  = '{0,   9,    1, 0, 0, 5,       10, 0,         0,         0,  1, 0};
    tbl[8]  = '{3,   1022, 1, 0, 0, 128,      0, 10368,     10368,     0, 10, 3};
    tbl[9]  = '{1,   50,  16, 0, 0, 1,        0, 27,        27,        0, 19, 1};
    tbl[10] = '{2,   60,  17, 0, 0, 1,        0, 0,         0,         1, 19, 1};

    rst = 1'b0;
    #12;
    chk("reset_cmd_ready", longint'(cmd_ready), 1);
    chk("reset_out_valid", longint'(out_valid), 0);
    chk("reset_rd_en", longint'(buf_rd_en), 0);
    chk("reset_mul_start", longint'(mul_start), 0);
    chk("reset_out_data", longint'(out_data), 0);
    rst = 1'b1;
    step();

    for (int t = 0; t < 11; t++) run_cmd(tbl[t], 1'b0);

    // Reset while group 2 of 4 is waiting on the array.
    mmode = 0; vmode = 0; val = 128; lat = 2; cnt = 0; nstart = 0; addrq.delete();
    cmd_valid = 1'b1; cmd_groups = 8'd4; cmd_base = 10'd40;
    step();
    cmd_valid = 1'b0;
    for (int k = 0; k < 100 && nstart < 2; k++) step();
    chk("rst_seq_two_starts", nstart, 2);
    step();
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_cmd_ready", longint'(cmd_ready), 1);
    chk("rst_mid_out_valid", longint'(out_valid), 0);
    chk("rst_mid_rd_en", longint'(buf_rd_en), 0);
    chk("rst_mid_rd_addr", longint'(buf_rd_addr), 0);
    chk("rst_mid_mul_start", longint'(mul_start), 0);
    chk("rst_mid_out_data", longint'(out_data), 0);
    chk("rst_mid_out_err", longint'(out_err), 0);
    cnt = 0; mmode = 3;
    #2 rst = 1'b1;
    mul_valid = 1'b1;
    step();
    mul_valid = 1'b0;
    begin
      bit act = 1'b0;
      for (int k = 0; k < 20; k++) begin
        step();
        if (out_valid || buf_rd_en || mul_start || !cmd_ready) act = 1'b1;
      end
      chk("late_valid_ignored", longint'(act), 0);
    end
    rv = '{1, 77, 2, 0, 0, 128, 0, 3456, 3456, 0, 5, 1};
    run_cmd(rv, 1'b0);

    // Random groups/base/latency with random lane products against the model.
    for (int r = 0; r < 25; r++) begin
      rv.groups = $urandom_range(0, 12);
      rv.base   = $urandom_range(0, 1023);
      rv.lat    = $urandom_range(1, 6);
      rv.mmode  = 0;
      rv.vmode  = 2;
      rv.val    = 0;
      rv.hold   = $urandom_range(0, 3);
      rv.e32    = 0;
      rv.e26    = 0;
      rv.eerr   = 0;
      rv.elat   = rv.groups * (2 + rv.lat) + 1;
      rv.ereads = rv.groups;
      run_cmd(rv, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
